// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: N-master to 1-slave arbiter for the cache-line SRAM bus.
// Read and write channels are arbitrated independently (round-robin or fixed
// priority). Accepted reads are tracked in an ID FIFO so that in-order slave
// responses are steered back to the master that issued them.
module sram_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 256,
    parameter int TYPE_W         = 6,
    parameter int STRB_W         = 16,
    parameter int RD_OUTSTANDING = 4,
    parameter int ARB_MODE       = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // master read request channel
    input  logic [NUM_MASTERS-1:0]            m_r_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_r_addr,
    input  logic [NUM_MASTERS*TYPE_W-1:0]     m_r_type,
    output logic [NUM_MASTERS-1:0]            m_r_rdy,
    // master read response channel
    output logic [LINE_W-1:0]                 m_re_data,
    output logic [NUM_MASTERS-1:0]            m_re_valid,
    // master write channel
    input  logic [NUM_MASTERS-1:0]            m_w_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_w_addr,
    input  logic [NUM_MASTERS*LINE_W-1:0]     m_w_data,
    input  logic [NUM_MASTERS*TYPE_W-1:0]     m_w_type,
    input  logic [NUM_MASTERS*STRB_W-1:0]     m_w_strb,
    output logic [NUM_MASTERS-1:0]            m_w_rdy,
    // slave read request channel
    output logic                              s_r_req,
    output logic [ADDR_W-1:0]                 s_r_addr,
    output logic [TYPE_W-1:0]                 s_r_type,
    input  logic                              s_r_rdy,
    // slave read response channel
    input  logic [LINE_W-1:0]                 s_re_data,
    input  logic                              s_re_valid,
    // slave write channel
    output logic                              s_w_req,
    output logic [ADDR_W-1:0]                 s_w_addr,
    output logic [LINE_W-1:0]                 s_w_data,
    output logic [TYPE_W-1:0]                 s_w_type,
    output logic [STRB_W-1:0]                 s_w_strb,
    input  logic                              s_w_rdy,
    // status
    output logic [$clog2(RD_OUTSTANDING+1)-1:0] rd_inflight,
    output logic                              rsp_err
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int PTR_W = (RD_OUTSTANDING > 1) ? $clog2(RD_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(RD_OUTSTANDING + 1);

    typedef enum logic {R_IDLE, R_GRANT} r_state_t;
    typedef enum logic {W_IDLE, W_GRANT} w_state_t;

    // Round-robin searches upward from ptr with wrap; fixed mode takes the lowest index.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                     input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (ARB_MODE == 1) idx = k;
            else               idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Pointer moves to the master after the winner, wrapping at NUM_MASTERS-1.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        if (int'(w) == NUM_MASTERS - 1) return '0;
        return w + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] fifo_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == RD_OUTSTANDING - 1) return '0;
        return p + 1'b1;
    endfunction

    r_state_t          r_state, r_state_nxt;
    w_state_t          w_state, w_state_nxt;
    logic [IDX_W-1:0]  rg, r_ptr;
    logic [IDX_W-1:0]  wg, w_ptr;
    logic              r_req_sel;
    logic              r_issue;
    logic              r_hs;
    logic              w_hs;

    logic [IDX_W-1:0]  fifo_mem [RD_OUTSTANDING];
    logic [PTR_W-1:0]  fifo_wr_ptr, fifo_rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_full, fifo_empty;
    logic              fifo_push, fifo_pop;
    logic [IDX_W-1:0]  fifo_head;

    assign r_req_sel  = m_r_req[rg];
    assign fifo_full  = (fifo_cnt == CNT_W'(RD_OUTSTANDING));
    assign fifo_empty = (fifo_cnt == '0);
    // A read only issues while the granted master still requests and an ID slot is free.
    assign r_issue    = (r_state == R_GRANT) && r_req_sel && !fifo_full;
    assign r_hs       = r_issue && s_r_rdy;
    assign w_hs       = (w_state == W_GRANT) && s_w_rdy;
    assign fifo_push  = r_hs;
    assign fifo_pop   = s_re_valid && !fifo_empty;
    assign fifo_head  = fifo_mem[fifo_rd_ptr];
    assign rd_inflight = fifo_cnt;

    // ---------------- read channel ----------------

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_state_nxt;
    end

    // Latch the read winner on leaving idle; advance the round-robin pointer on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rg    <= '0;
            r_ptr <= '0;
        end else begin
            if (r_state == R_IDLE && |m_r_req) rg <= pick_winner(m_r_req, r_ptr);
            if (r_hs) r_ptr <= next_ptr(rg);
        end
    end

    // Read FSM next state; a withdrawn request also returns to idle so the channel cannot wedge.
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (|m_r_req) r_state_nxt = R_GRANT;
            R_GRANT: if (r_hs || !r_req_sel) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs: slave request fields muxed from the winner, accept pulse to the winner.
    always_comb begin
        s_r_req  = 1'b0;
        s_r_addr = '0;
        s_r_type = '0;
        m_r_rdy  = '0;
        if (r_state == R_GRANT) begin
            s_r_req = r_issue;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (rg == IDX_W'(i)) begin
                    s_r_addr = m_r_addr[i*ADDR_W +: ADDR_W];
                    s_r_type = m_r_type[i*TYPE_W +: TYPE_W];
                end
            end
            if (r_hs) m_r_rdy[rg] = 1'b1;
        end
    end

    // ---------------- write channel ----------------

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_state_nxt;
    end

    // Latch the write winner on leaving idle; advance the write pointer on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wg    <= '0;
            w_ptr <= '0;
        end else begin
            if (w_state == W_IDLE && |m_w_req) wg <= pick_winner(m_w_req, w_ptr);
            if (w_hs) w_ptr <= next_ptr(wg);
        end
    end

    // Write FSM next state.
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (|m_w_req) w_state_nxt = W_GRANT;
            W_GRANT: if (s_w_rdy) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: all write fields from the winner, done pulse on slave ready.
    always_comb begin
        s_w_req  = 1'b0;
        s_w_addr = '0;
        s_w_data = '0;
        s_w_type = '0;
        s_w_strb = '0;
        m_w_rdy  = '0;
        if (w_state == W_GRANT) begin
            s_w_req = 1'b1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (wg == IDX_W'(i)) begin
                    s_w_addr = m_w_addr[i*ADDR_W +: ADDR_W];
                    s_w_data = m_w_data[i*LINE_W +: LINE_W];
                    s_w_type = m_w_type[i*TYPE_W +: TYPE_W];
                    s_w_strb = m_w_strb[i*STRB_W +: STRB_W];
                end
            end
            if (w_hs) m_w_rdy[wg] = 1'b1;
        end
    end

    // ---------------- ID FIFO and response path ----------------

    // ID FIFO pointers and occupancy; push is already blocked when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_inc(fifo_wr_ptr);
            if (fifo_pop)  fifo_rd_ptr <= fifo_inc(fifo_rd_ptr);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ID FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[fifo_wr_ptr] <= rg;
    end

    // Route a response to the master at the FIFO head; data is zero when nothing is routed.
    always_comb begin
        m_re_valid = '0;
        m_re_data  = '0;
        if (fifo_pop) begin
            m_re_valid[fifo_head] = 1'b1;
            m_re_data             = s_re_data;
        end
    end

    // Sticky error for a response that arrives with no read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         rsp_err <= 1'b0;
        else if (s_re_valid && fifo_empty)  rsp_err <= 1'b1;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: randomized masters/slave against a
// transaction-level reference model, plus directed scenarios.
module tb_sram_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int TW  = 6;
    localparam int SW  = 16;
    localparam int RDO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    m_r_req, m_w_req;
    logic [N*AW-1:0] m_r_addr, m_w_addr;
    logic [N*TW-1:0] m_r_type, m_w_type;
    logic [N*LW-1:0] m_w_data;
    logic [N*SW-1:0] m_w_strb;
    logic            s_r_rdy, s_w_rdy, s_re_valid;
    logic [LW-1:0]   s_re_data;

    logic [N-1:0] m_r_rdy, m_re_valid, m_w_rdy;
    logic [LW-1:0] m_re_data, s_w_data;
    logic s_r_req, s_w_req, rsp_err;
    logic [AW-1:0] s_r_addr, s_w_addr;
    logic [TW-1:0] s_r_type, s_w_type;
    logic [SW-1:0] s_w_strb;
    logic [2:0] rd_inflight;

    logic [N-1:0] f_m_r_rdy, f_m_re_valid, f_m_w_rdy;
    logic [LW-1:0] f_m_re_data, f_s_w_data;
    logic f_s_r_req, f_s_w_req, f_rsp_err;
    logic [AW-1:0] f_s_r_addr, f_s_w_addr;
    logic [TW-1:0] f_s_r_type, f_s_w_type;
    logic [SW-1:0] f_s_w_strb;
    logic [2:0] f_rd_inflight;

    sram_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .LINE_W(LW), .TYPE_W(TW), .STRB_W(SW),
                       .RD_OUTSTANDING(RDO), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
        .m_re_data(m_re_data), .m_re_valid(m_re_valid),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
        .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_type(s_w_type),
        .s_w_strb(s_w_strb), .s_w_rdy(s_w_rdy),
        .rd_inflight(rd_inflight), .rsp_err(rsp_err)
    );

    sram_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .LINE_W(LW), .TYPE_W(TW), .STRB_W(SW),
                       .RD_OUTSTANDING(RDO), .ARB_MODE(1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(f_m_r_rdy),
        .m_re_data(f_m_re_data), .m_re_valid(f_m_re_valid),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_type(m_w_type),
        .m_w_strb(m_w_strb), .m_w_rdy(f_m_w_rdy),
        .s_r_req(f_s_r_req), .s_r_addr(f_s_r_addr), .s_r_type(f_s_r_type), .s_r_rdy(s_r_rdy),
        .s_re_data(s_re_data), .s_re_valid(s_re_valid),
        .s_w_req(f_s_w_req), .s_w_addr(f_s_w_addr), .s_w_data(f_s_w_data), .s_w_type(f_s_w_type),
        .s_w_strb(f_s_w_strb), .s_w_rdy(s_w_rdy),
        .rd_inflight(f_rd_inflight), .rsp_err(f_rsp_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending decision per channel, round-robin pointers,
    // queue of issued read IDs, sticky error.
    bit r_busy, w_busy, err;
    int r_win, w_win, r_ptr, w_ptr;
    int q[$];
    int due[$];
    logic [N-1:0] rel_r, rel_w;
    logic [N-1:0] dut_grants[$];
    int acc_cnt, cyc;

    // Stimulus knobs
    logic [N-1:0] rd_en, wr_en;
    int rd_prob, wr_prob, r_rdy_prob, w_rdy_prob, rsp_mode;
    bit one_shot, fix_on;
    int fix_grants;

    function automatic int arb(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        r_busy = 0; w_busy = 0; err = 0;
        r_ptr = 0; w_ptr = 0; r_win = 0; w_win = 0;
        q.delete(); due.delete();
        rel_r = '0; rel_w = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rel_r[i]) m_r_req[i] = 1'b0;
            if (!m_r_req[i] && rd_en[i] && int'($urandom_range(99)) < rd_prob) begin
                m_r_req[i] = 1'b1;
                m_r_addr[i*AW +: AW] = $urandom;
                m_r_type[i*TW +: TW] = TW'($urandom);
            end
            if (rel_w[i]) m_w_req[i] = 1'b0;
            if (!m_w_req[i] && wr_en[i] && int'($urandom_range(99)) < wr_prob) begin
                m_w_req[i] = 1'b1;
                m_w_addr[i*AW +: AW] = $urandom;
                m_w_type[i*TW +: TW] = TW'($urandom);
                m_w_strb[i*SW +: SW] = SW'($urandom);
                m_w_data[i*LW +: LW] = rand_line();
            end
        end
        rel_r = '0;
        rel_w = '0;
        s_r_rdy = int'($urandom_range(99)) < r_rdy_prob;
        s_w_rdy = int'($urandom_range(99)) < w_rdy_prob;
        s_re_data = rand_line();
        s_re_valid = 1'b0;
        if (one_shot) begin
            s_re_valid = 1'b1;
            one_shot = 0;
        end else if (rsp_mode == 1) begin
            s_re_valid = (q.size() > 0) && ($urandom_range(2) == 0);
        end else if (rsp_mode == 2) begin
            if (due.size() > 0 && due[0] <= cyc) begin
                s_re_valid = 1'b1;
                void'(due.pop_front());
            end
        end
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model.
    task automatic eval();
        logic [N-1:0] e_rrdy, e_wrdy, e_rev;
        logic [AW-1:0] e_raddr, e_waddr;
        logic [TW-1:0] e_rtype, e_wtype;
        logic [SW-1:0] e_wstrb;
        logic [LW-1:0] e_wdata, e_rdata;
        bit e_sr, pop, r_hs, w_hs;
        #1;
        e_sr    = r_busy && m_r_req[r_win] && (q.size() < RDO);
        e_raddr = r_busy ? m_r_addr[r_win*AW +: AW] : '0;
        e_rtype = r_busy ? m_r_type[r_win*TW +: TW] : '0;
        r_hs    = e_sr && s_r_rdy;
        e_rrdy  = '0;
        if (r_hs) e_rrdy[r_win] = 1'b1;
        e_waddr = w_busy ? m_w_addr[w_win*AW +: AW] : '0;
        e_wtype = w_busy ? m_w_type[w_win*TW +: TW] : '0;
        e_wstrb = w_busy ? m_w_strb[w_win*SW +: SW] : '0;
        e_wdata = w_busy ? m_w_data[w_win*LW +: LW] : '0;
        w_hs    = w_busy && s_w_rdy;
        e_wrdy  = '0;
        if (w_hs) e_wrdy[w_win] = 1'b1;
        pop     = s_re_valid && (q.size() > 0);
        e_rev   = '0;
        e_rdata = '0;
        if (pop) begin
            e_rev[q[0]] = 1'b1;
            e_rdata = s_re_data;
        end

        check_eq("s_r_req", s_r_req, e_sr);
        check_eq("s_r_addr", s_r_addr, e_raddr);
        check_eq("s_r_type", s_r_type, e_rtype);
        check_eq("m_r_rdy", m_r_rdy, e_rrdy);
        check_eq("s_w_req", s_w_req, w_busy);
        check_eq("s_w_addr", s_w_addr, e_waddr);
        check_eq("s_w_type", s_w_type, e_wtype);
        check_eq("s_w_strb", s_w_strb, e_wstrb);
        check_eq("s_w_data", s_w_data, e_wdata);
        check_eq("m_w_rdy", m_w_rdy, e_wrdy);
        check_eq("m_re_valid", m_re_valid, e_rev);
        check_eq("m_re_data", m_re_data, e_rdata);
        check_eq("rd_inflight", rd_inflight, q.size());
        check_eq("rsp_err", rsp_err, err);

        if (m_r_rdy != '0) dut_grants.push_back(m_r_rdy);
        if (fix_on && f_m_r_rdy != '0) begin
            fix_grants++;
            check_eq("fix_grant", f_m_r_rdy, 4'b0010);
        end

        if (s_re_valid && q.size() == 0) err = 1;
        if (pop) void'(q.pop_front());
        if (r_hs) begin
            q.push_back(r_win);
            acc_cnt++;
            if (rsp_mode == 2) due.push_back(cyc + 3);
            rel_r[r_win] = 1'b1;
            r_ptr  = (r_win + 1) % N;
            r_busy = 0;
        end else if (!r_busy && m_r_req != '0) begin
            r_win  = arb(m_r_req, r_ptr);
            r_busy = 1;
        end
        if (w_hs) begin
            rel_w[w_win] = 1'b1;
            w_ptr  = (w_win + 1) % N;
            w_busy = 0;
        end else if (!w_busy && m_w_req != '0) begin
            w_win  = arb(m_w_req, w_ptr);
            w_busy = 1;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        eval();
    endtask

    task automatic drain();
        int t;
        rd_en = '0; wr_en = '0;
        r_rdy_prob = 100; w_rdy_prob = 100;
        rsp_mode = 1;
        due.delete();
        t = 0;
        while ((m_r_req != '0 || m_w_req != '0 || r_busy || w_busy || q.size() > 0) && t < 500) begin
            step();
            t++;
        end
        check_eq("drain_done", t < 500, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        m_r_req = '0; m_w_req = '0;
        s_r_rdy = 0; s_w_rdy = 0; s_re_valid = 0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_r_req = '0; m_w_req = '0;
        m_r_addr = '0; m_w_addr = '0; m_r_type = '0; m_w_type = '0;
        m_w_data = '0; m_w_strb = '0;
        s_r_rdy = 0; s_w_rdy = 0; s_re_valid = 0; s_re_data = '0;
        rd_en = '0; wr_en = '0; rd_prob = 0; wr_prob = 0;
        r_rdy_prob = 0; w_rdy_prob = 0; rsp_mode = 0;
        one_shot = 0; fix_on = 0; fix_grants = 0; acc_cnt = 0; cyc = 0;
        model_reset();

        // Reset state
        #1;
        check_eq("rst_s_r_req", s_r_req, 1'b0);
        check_eq("rst_s_w_req", s_w_req, 1'b0);
        check_eq("rst_m_r_rdy", m_r_rdy, '0);
        check_eq("rst_m_w_rdy", m_w_rdy, '0);
        check_eq("rst_m_re_valid", m_re_valid, '0);
        check_eq("rst_s_r_addr", s_r_addr, '0);
        check_eq("rst_m_re_data", m_re_data, '0);
        check_eq("rst_rd_inflight", rd_inflight, '0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness: all masters hold read requests, responses 3 cycles after accept
        rd_en = '1; rd_prob = 100; r_rdy_prob = 100; rsp_mode = 2;
        dut_grants.delete();
        repeat (12) step();
        check_eq("rr_count", dut_grants.size() >= 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] eo;
            eo = '0;
            eo[k % N] = 1'b1;
            if (k < dut_grants.size()) check_eq($sformatf("rr_grant%0d", k), dut_grants[k], eo);
        end
        check_eq("rr_rsp_err", rsp_err, 1'b0);
        drain();

        // Concurrent read and write handshake in the same cycle
        r_rdy_prob = 100; w_rdy_prob = 100; rsp_mode = 0;
        @(negedge clk);
        drive();
        m_w_req[0] = 1'b1;
        m_w_addr[0 +: AW] = 32'h8000_1000;
        m_w_strb[0 +: SW] = 16'hA5C3;
        m_w_data[0 +: LW] = rand_line();
        m_r_req[2] = 1'b1;
        m_r_addr[2*AW +: AW] = 32'h8000_2000;
        eval();
        step();
        check_eq("conc_m_w_rdy", m_w_rdy, 4'b0001);
        check_eq("conc_m_r_rdy", m_r_rdy, 4'b0100);
        check_eq("conc_s_w_addr", s_w_addr, 32'h8000_1000);
        check_eq("conc_s_r_addr", s_r_addr, 32'h8000_2000);
        check_eq("conc_s_w_strb", s_w_strb, 16'hA5C3);
        drain();

        // Outstanding limit: no responses until the FIFO fills
        rd_en = '1; rd_prob = 100; r_rdy_prob = 100; rsp_mode = 0;
        acc_cnt = 0;
        repeat (12) step();
        check_eq("lim_accepts", acc_cnt, 4);
        check_eq("lim_inflight", rd_inflight, 3'd4);
        check_eq("lim_s_r_req", s_r_req, 1'b0);
        one_shot = 1;
        step();
        step();
        check_eq("lim_inflight_after_pop", rd_inflight, 3'd3);
        check_eq("lim_fifth_accept", acc_cnt, 5);
        drain();

        // Fixed priority instance: masters 1 and 3 request continuously
        do_reset();
        rd_en = 4'b1010; rd_prob = 100; r_rdy_prob = 100; rsp_mode = 1;
        fix_on = 1; fix_grants = 0;
        repeat (40) step();
        fix_on = 0;
        check_eq("fix_any_grant", fix_grants > 0, 1'b1);
        drain();

        // Randomized traffic on both channels
        rd_en = '1; wr_en = '1; rd_prob = 30; wr_prob = 30;
        r_rdy_prob = 60; w_rdy_prob = 60; rsp_mode = 1;
        repeat (1500) begin
            @(negedge clk);
            drive();
            r_rdy_prob = 60; w_rdy_prob = 60;
            eval();
        end
        drain();

        // Spurious response with nothing in flight
        one_shot = 1;
        step();
        check_eq("spur_m_re_valid", m_re_valid, '0);
        step();
        check_eq("spur_rsp_err", rsp_err, 1'b1);
        repeat (5) step();
        check_eq("spur_rsp_err_sticky", rsp_err, 1'b1);

        // Reset in the middle of a grant with two reads in flight and a write pending
        rd_en = '1; rd_prob = 100; r_rdy_prob = 100; rsp_mode = 0;
        wr_en = '1; wr_prob = 100; w_rdy_prob = 0;
        for (int t = 0; t < 50 && q.size() < 2; t++) step();
        r_rdy_prob = 0;
        for (int t = 0; t < 10 && !r_busy; t++) step();
        check_eq("mid_two_inflight", rd_inflight, 3'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_s_r_req", s_r_req, 1'b0);
        check_eq("mid_s_w_req", s_w_req, 1'b0);
        check_eq("mid_m_r_rdy", m_r_rdy, '0);
        check_eq("mid_m_w_rdy", m_w_rdy, '0);
        check_eq("mid_s_r_addr", s_r_addr, '0);
        check_eq("mid_s_w_data", s_w_data, '0);
        check_eq("mid_rd_inflight", rd_inflight, '0);
        check_eq("mid_rsp_err", rsp_err, 1'b0);
        rd_en = '0; wr_en = '0; rsp_mode = 0;
        m_r_req = '0; m_w_req = '0;
        s_r_rdy = 0; s_w_rdy = 0; s_re_valid = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        one_shot = 1;
        step();
        step();
        check_eq("post_rst_rsp_err", rsp_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
